// File: rtl/qa_pkg.sv
// Shared constants for the tag-labelled store front end: geometry, tag
// encodings and the write-side state machine encoding.
package qa_pkg;

    localparam int QA_DEPTH  = 16;
    localparam int QA_IDX_W  = 4;
    localparam int QA_DATA_W = 3;

    localparam logic QA_TAG_L = 1'b0;
    localparam logic QA_TAG_H = 1'b1;

    localparam logic [1:0] QA_ST_INIT   = 2'd0;
    localparam logic [1:0] QA_ST_IDLE   = 2'd1;
    localparam logic [1:0] QA_ST_COMMIT = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT   = QA_ST_INIT,
        ST_IDLE   = QA_ST_IDLE,
        ST_COMMIT = QA_ST_COMMIT
    } state_t;

endpackage

// File: rtl/tag_scrub_writer.sv
// Write-side front end for the tag-labelled store. Same-tag requests become
// a single store write; a tag change becomes a scrub write (old tag, zero
// data) immediately followed by the commit write (new tag, new data), so an
// entry's data and tag never change in one store write. A shadow copy of all
// tags is kept and exported for read-side muxing.
// Optional build macro TAG_SCRUB_INIT_CLEAR_EN: after reset, sweep every
// entry to (tag L, data 0) before accepting requests.
module tag_scrub_writer
    import qa_pkg::*;
#(
    parameter int DEPTH  = QA_DEPTH,
    parameter int IDX_W  = QA_IDX_W,
    parameter int DATA_W = QA_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_idx,
    input  logic              req_tag,
    input  logic [DATA_W-1:0] req_data,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_idx,
    output logic              wr_tag,
    output logic [DATA_W-1:0] wr_data,
    output logic [DEPTH-1:0]  tags_q
);

`ifdef TAG_SCRUB_INIT_CLEAR_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t              state_reg, state_next;
    logic                wr_en_reg, wr_en_next;
    logic [IDX_W-1:0]    wr_idx_reg, wr_idx_next;
    logic                wr_tag_reg, wr_tag_next;
    logic [DATA_W-1:0]   wr_data_reg, wr_data_next;
    logic [DEPTH-1:0]    tags_reg, tags_next;
    logic [IDX_W-1:0]    pend_idx_reg, pend_idx_next;
    logic                pend_tag_reg, pend_tag_next;
    logic [DATA_W-1:0]   pend_data_reg, pend_data_next;
`ifdef TAG_SCRUB_INIT_CLEAR_EN
    logic [IDX_W-1:0]    sweep_reg, sweep_next;
`endif
    logic                accept;
    logic                cur_tag;

    assign req_ready = (state_reg == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign cur_tag   = tags_reg[req_idx];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and next-value logic for the write bank, shadow tags and pending request
    always_comb begin
        state_next     = state_reg;
        wr_en_next     = 1'b0;
        wr_idx_next    = wr_idx_reg;
        wr_tag_next    = wr_tag_reg;
        wr_data_next   = wr_data_reg;
        tags_next      = tags_reg;
        pend_idx_next  = pend_idx_reg;
        pend_tag_next  = pend_tag_reg;
        pend_data_next = pend_data_reg;
`ifdef TAG_SCRUB_INIT_CLEAR_EN
        sweep_next     = sweep_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    wr_en_next  = 1'b1;
                    wr_idx_next = req_idx;
                    if (req_tag == cur_tag) begin
                        wr_tag_next  = req_tag;
                        wr_data_next = req_data;
                    end else begin
                        // Scrub under the old tag first; the real data follows next cycle
                        wr_tag_next    = cur_tag;
                        wr_data_next   = '0;
                        pend_idx_next  = req_idx;
                        pend_tag_next  = req_tag;
                        pend_data_next = req_data;
                        state_next     = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                wr_en_next              = 1'b1;
                wr_idx_next             = pend_idx_reg;
                wr_tag_next             = pend_tag_reg;
                wr_data_next            = pend_data_reg;
                tags_next[pend_idx_reg] = pend_tag_reg;
                state_next              = ST_IDLE;
            end
`ifdef TAG_SCRUB_INIT_CLEAR_EN
            ST_INIT: begin
                wr_en_next   = 1'b1;
                wr_idx_next  = sweep_reg;
                wr_tag_next  = QA_TAG_L;
                wr_data_next = '0;
                sweep_next   = sweep_reg + 1'b1;
                if (sweep_reg == IDX_W'(DEPTH - 1)) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output register bank, shadow tags and pending request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_reg     <= 1'b0;
            wr_idx_reg    <= '0;
            wr_tag_reg    <= QA_TAG_L;
            wr_data_reg   <= '0;
            tags_reg      <= '0;
            pend_idx_reg  <= '0;
            pend_tag_reg  <= QA_TAG_L;
            pend_data_reg <= '0;
`ifdef TAG_SCRUB_INIT_CLEAR_EN
            sweep_reg     <= '0;
`endif
        end else begin
            wr_en_reg     <= wr_en_next;
            wr_idx_reg    <= wr_idx_next;
            wr_tag_reg    <= wr_tag_next;
            wr_data_reg   <= wr_data_next;
            tags_reg      <= tags_next;
            pend_idx_reg  <= pend_idx_next;
            pend_tag_reg  <= pend_tag_next;
            pend_data_reg <= pend_data_next;
`ifdef TAG_SCRUB_INIT_CLEAR_EN
            sweep_reg     <= sweep_next;
`endif
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_idx  = wr_idx_reg;
    assign wr_tag  = wr_tag_reg;
    assign wr_data = wr_data_reg;
    assign tags_q  = tags_reg;

endmodule

// File: tb/tb_tag_scrub_writer.sv
// Self-checking bench for tag_scrub_writer. Stimulus pushes the expected
// store writes into a queue using a plain per-entry tag array as the model;
// a monitor pops and compares on every cycle with wr_en high. Honours
// TAG_SCRUB_INIT_CLEAR_EN when defined.
module tb_tag_scrub_writer;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [IDX_W-1:0]  req_idx = '0;
    logic              req_tag = 1'b0;
    logic [DATA_W-1:0] req_data = '0;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic [DEPTH-1:0]  tags_q;

    tag_scrub_writer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_idx(req_idx), .req_tag(req_tag), .req_data(req_data),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag), .wr_data(wr_data),
        .tags_q(tags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic              tag;
        logic [DATA_W-1:0] data;
        logic [DEPTH-1:0]  tags;
        logic              ready;
        int                due;
    } exp_t;

    exp_t             exp_q[$];
    logic [DEPTH-1:0] mtags = '0;
    int               cyc = 0;
    int               n_cmp = 0;
    int               n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every store write must match the head of the expected queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_write: got idx=%0d tag=%0d data=%0d at cyc=%0d, want no write",
                             wr_idx, wr_tag, wr_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (wr_idx !== e.idx || wr_tag !== e.tag || wr_data !== e.data ||
                        tags_q !== e.tags || req_ready !== e.ready || cyc != e.due) begin
                        n_bad = n_bad + 1;
                        $display("FAIL write: got idx=%0d tag=%0d data=%0d tags=%h ready=%0d cyc=%0d, want idx=%0d tag=%0d data=%0d tags=%h ready=%0d cyc=%0d",
                                 wr_idx, wr_tag, wr_data, tags_q, req_ready, cyc,
                                 e.idx, e.tag, e.data, e.tags, e.ready, e.due);
                    end else begin
                        $display("write ok: idx=%0d tag=%0d data=%0d tags=%h cyc=%0d",
                                 wr_idx, wr_tag, wr_data, tags_q, cyc);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp = n_cmp + 1;
                n_bad = n_bad + 1;
                $display("FAIL missing_write: got wr_en=0 at cyc=%0d, want idx=%0d tag=%0d data=%0d",
                         cyc, e.idx, e.tag, e.data);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end else begin
            $display("check ok: %s = %h", name, got);
        end
    endtask

    task automatic push(input logic [IDX_W-1:0] i, input logic t, input logic [DATA_W-1:0] d,
                        input logic rdy, input int due);
        exp_t e;
        e.idx = i; e.tag = t; e.data = d; e.tags = mtags; e.ready = rdy; e.due = due;
        exp_q.push_back(e);
    endtask

    // Drive a request until it is accepted; expected writes come from the tag model
    task automatic send(input logic [IDX_W-1:0] i, input logic t, input logic [DATA_W-1:0] d);
        int  waited = 0;
        bit  done = 0;
        while (!done) begin
            @(negedge clk);
            req_valid = 1'b1; req_idx = i; req_tag = t; req_data = d;
            if (req_ready) begin
                done = 1;
                if (t == mtags[i]) begin
                    push(i, t, d, 1'b1, cyc + 1);
                end else begin
                    push(i, mtags[i], '0, 1'b0, cyc + 1);
                    mtags[i] = t;
                    push(i, t, d, 1'b1, cyc + 2);
                end
            end else begin
                waited = waited + 1;
                if (waited > 20) begin
                    n_cmp = n_cmp + 1;
                    n_bad = n_bad + 1;
                    $display("FAIL ready_timeout: got req_ready=0 for %0d cycles, want 1", waited);
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
            req_idx   = IDX_W'($urandom);
            req_tag   = 1'($urandom);
            req_data  = DATA_W'($urandom);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
`ifdef TAG_SCRUB_INIT_CLEAR_EN
        for (int k = 0; k < DEPTH; k++) begin
            push(IDX_W'(k), 1'b0, '0, (k == DEPTH - 1), cyc + 1 + k);
        end
        begin
            int w = 0;
            while (!req_ready && w < 40) begin
                @(negedge clk);
                w = w + 1;
            end
            check("sweep_then_ready", 32'(req_ready), 32'd1);
        end
`endif
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        mtags = '0;
        repeat (2) @(negedge clk);
    endtask

`ifdef TAG_SCRUB_INIT_CLEAR_EN
    localparam logic READY_IN_RESET = 1'b0;
`else
    localparam logic READY_IN_RESET = 1'b1;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        assert_reset();
        check("reset_wr_en",   32'(wr_en),     32'd0);
        check("reset_wr_idx",  32'(wr_idx),    32'd0);
        check("reset_wr_tag",  32'(wr_tag),    32'd0);
        check("reset_wr_data", 32'(wr_data),   32'd0);
        check("reset_tags_q",  32'(tags_q),    32'd0);
        check("reset_ready",   32'(req_ready), 32'(READY_IN_RESET));

`ifdef TAG_SCRUB_INIT_CLEAR_EN
        // Reset lands right after sweep index 9 was written; sweep must restart at 0
        begin
            int c0;
            @(negedge clk);
            rst_n = 1'b1;
            c0 = cyc;
            for (int k = 0; k < 10; k++) push(IDX_W'(k), 1'b0, '0, 1'b0, c0 + 1 + k);
            while (cyc < c0 + 10) @(negedge clk);
            #1 rst_n = 1'b0;
            exp_q.delete();
            repeat (2) @(negedge clk);
        end
`endif
        release_reset();

        // Same-tag stream, back to back
        send(4'd2, 1'b0, 3'd5);
        send(4'd7, 1'b0, 3'd1);
        idle(2);
        // Upgrade, then downgrade held through COMMIT, then same-tag reuse
        send(4'd4, 1'b1, 3'd6);
        idle(3);
        send(4'd4, 1'b0, 3'd3);
        send(4'd4, 1'b0, 3'd2);
        send(4'd4, 1'b1, 3'd7);
        send(4'd9, 1'b1, 3'd2);
        idle(2);

        // Randomized traffic over a narrow index range to force repeats
        for (int n = 0; n < 80; n++) begin
            idle($urandom_range(0, 2));
            send(IDX_W'($urandom_range(0, 7)), 1'($urandom), DATA_W'($urandom));
        end
        idle(3);
        check("tags_before_reset", 32'(tags_q), 32'(mtags));

        // Reset during COMMIT of an upgrade drops the commit
        send(4'd12, 1'b1, 3'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        mtags = '0;
        #1;
        check("rst_commit_wr_en",  32'(wr_en),     32'd0);
        check("rst_commit_tags_q", 32'(tags_q),    32'd0);
        check("rst_commit_ready",  32'(req_ready), 32'(READY_IN_RESET));
        repeat (2) @(negedge clk);
        release_reset();
        idle(4);

        send(4'd3, 1'b1, 3'd1);
        send(4'd3, 1'b1, 3'd6);
        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_tags_q",  32'(tags_q),       32'(mtags));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
